// File: rtl/project_reg_access_ctrl.sv
// project_reg_access_ctrl: byte-serial host framing into a register-file write/read port.
// A frame is a command byte (rw, inc, start address) followed by data bytes at up to one per cycle.
module project_reg_access_ctrl #(
    parameter int REG_COUNT = 49
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_host_cs,
    input  logic       i_host_valid,
    input  logic [7:0] i_host_data,
    output logic [7:0] o_host_rdata,
    output logic       o_host_rvalid,
    output logic       o_rf_write_en,
    output logic [5:0] o_rf_address,
    output logic [7:0] o_rf_data,
    input  logic [7:0] i_rf_data,
    output logic       o_busy,
    output logic       o_err,
    output logic [7:0] o_wr_count
);
    localparam logic [6:0] RC = 7'(REG_COUNT);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, WAIT_CS_LOW} state_t;

    state_t     state_q, state_d;
    logic       cs_q;
    logic [5:0] ptr_q, ptr_d;
    logic       inc_q, inc_d;
    logic       we_q, we_d;
    logic [5:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    logic       cs_rise, in_range;
    logic [5:0] ptr_next;

    assign cs_rise  = i_host_cs & ~cs_q;
    assign in_range = {1'b0, ptr_q} < RC;
    // out-of-range pointers also wrap to 0 when incrementing
    assign ptr_next = !inc_q ? ptr_q : ({1'b0, ptr_q} >= RC - 7'd1) ? 6'd0 : ptr_q + 6'd1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        inc_d    = inc_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (cs_rise) begin
                    state_d = CMD;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            CMD: begin
                if (!i_host_cs) state_d = IDLE;
                else if (i_host_valid) begin
                    ptr_d   = i_host_data[5:0];
                    inc_d   = i_host_data[6];
                    state_d = i_host_data[7] ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (!i_host_cs) state_d = IDLE;
                else if (i_host_valid) begin
                    ptr_d   = ptr_next;
                    we_d    = in_range;
                    waddr_d = in_range ? ptr_q : waddr_q;
                    wdata_d = in_range ? i_host_data : wdata_q;
                    cnt_d   = (!in_range || cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    err_d   = err_q | ~in_range;
                end
            end
            RDATA: begin
                if (!i_host_cs) state_d = IDLE;
                else if (i_host_valid) begin
                    ptr_d    = ptr_next;
                    rvalid_d = 1'b1;
                    rdata_d  = in_range ? i_rf_data : 8'h00;
                    err_d    = err_q | ~in_range;
                end
            end
            WAIT_CS_LOW: state_d = i_host_cs ? WAIT_CS_LOW : IDLE;
            default:     state_d = WAIT_CS_LOW;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= WAIT_CS_LOW;
            cs_q     <= 1'b0;
            ptr_q    <= 6'd0;
            inc_q    <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= 6'd0;
            wdata_q  <= 8'd0;
            rdata_q  <= 8'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cs_q     <= i_host_cs;
            ptr_q    <= ptr_d;
            inc_q    <= inc_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // outside a write pulse the address follows the pointer so i_rf_data is ready for reads
    assign o_rf_address  = we_q ? waddr_q : ptr_q;
    assign o_rf_write_en = we_q;
    assign o_rf_data     = wdata_q;
    assign o_host_rdata  = rdata_q;
    assign o_host_rvalid = rvalid_q;
    assign o_busy        = state_q != IDLE;
    assign o_err         = err_q;
    assign o_wr_count    = cnt_q;
endmodule

// File: tb/tb_project_reg_access_ctrl.sv
// tb_project_reg_access_ctrl: directed vector table, hand sequences for reset/saturation,
// and random frames checked against a frame-level reference model.
module tb_project_reg_access_ctrl;
    localparam int RC = 49;

    logic       clk = 1'b0, rst_n = 1'b0, cs = 1'b0, valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] rdata, wd, cnt, rf;
    logic       rv, we, err, busy;
    logic [5:0] addr;
    logic [7:0] mem [64];
    logic [7:0] mem_ref [64];
    logic       rf_fix_en = 1'b1;
    logic [7:0] rf_fix = 8'hA5;
    int         tests = 0, fails = 0;
    logic [13:0] obs_w[$];
    logic [7:0]  obs_r[$];

    typedef struct {
        logic cs, v; logic [7:0] d;
        logic we; logic [5:0] a; logic [7:0] wd; logic rv; logic [7:0] rd;
        logic err; logic [7:0] cnt; logic busy;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;
    assign rf = rf_fix_en ? rf_fix : mem[addr];

    project_reg_access_ctrl #(.REG_COUNT(RC)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_host_cs(cs), .i_host_valid(valid),
        .i_host_data(din), .o_host_rdata(rdata), .o_host_rvalid(rv),
        .o_rf_write_en(we), .o_rf_address(addr), .o_rf_data(wd), .i_rf_data(rf),
        .o_busy(busy), .o_err(err), .o_wr_count(cnt)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic v, input logic [7:0] d);
        @(negedge clk);
        cs = c; valid = v; din = d;
        @(posedge clk);
        #1;
        if (we === 1'b1) begin
            obs_w.push_back({addr, wd});
            mem[addr] = wd;
        end
        if (rv === 1'b1) obs_r.push_back(rdata);
    endtask

    task automatic add(input logic c, input logic v, input logic [7:0] d, input logic e_we,
                       input logic [5:0] e_a, input logic [7:0] e_wd, input logic e_rv,
                       input logic [7:0] e_rd, input logic e_err, input logic [7:0] e_cnt,
                       input logic e_busy);
        vec_t t;
        t.cs = c; t.v = v; t.d = d; t.we = e_we; t.a = e_a; t.wd = e_wd; t.rv = e_rv;
        t.rd = e_rd; t.err = e_err; t.cnt = e_cnt; t.busy = e_busy;
        tv.push_back(t);
    endtask

    function automatic logic [33:0] outs_now();
        return {we, addr, wd, rv, rdata, err, cnt, busy};
    endfunction

    initial begin
        logic [7:0] last;
        // burst write, range error, wrap, abort, read no-inc, out-of-range read
        add(0,0,8'h00, 0,6'h00,8'h00,0,8'h00,0,8'd0,0);
        add(1,0,8'h00, 0,6'h00,8'h00,0,8'h00,0,8'd0,1);
        add(1,1,8'hC3, 0,6'h03,8'h00,0,8'h00,0,8'd0,1);
        add(1,1,8'h11, 1,6'h03,8'h11,0,8'h00,0,8'd1,1);
        add(1,1,8'h22, 1,6'h04,8'h22,0,8'h00,0,8'd2,1);
        add(1,1,8'h33, 1,6'h05,8'h33,0,8'h00,0,8'd3,1);
        add(1,0,8'h00, 0,6'h06,8'h33,0,8'h00,0,8'd3,1);
        add(0,0,8'h00, 0,6'h06,8'h33,0,8'h00,0,8'd3,0);
        add(1,0,8'h00, 0,6'h06,8'h33,0,8'h00,0,8'd0,1);
        add(1,1,8'hB5, 0,6'h35,8'h33,0,8'h00,0,8'd0,1);
        add(1,1,8'h7E, 0,6'h35,8'h33,0,8'h00,1,8'd0,1);
        add(0,0,8'h00, 0,6'h35,8'h33,0,8'h00,1,8'd0,0);
        add(1,0,8'h00, 0,6'h35,8'h33,0,8'h00,0,8'd0,1);
        add(1,1,8'hF0, 0,6'h30,8'h33,0,8'h00,0,8'd0,1);
        add(1,1,8'h01, 1,6'h30,8'h01,0,8'h00,0,8'd1,1);
        add(1,1,8'h02, 1,6'h00,8'h02,0,8'h00,0,8'd2,1);
        add(0,0,8'h00, 0,6'h01,8'h02,0,8'h00,0,8'd2,0);
        add(1,0,8'h00, 0,6'h01,8'h02,0,8'h00,0,8'd0,1);
        add(1,1,8'hC7, 0,6'h07,8'h02,0,8'h00,0,8'd0,1);
        add(0,1,8'h55, 0,6'h07,8'h02,0,8'h00,0,8'd0,0);
        add(1,0,8'h00, 0,6'h07,8'h02,0,8'h00,0,8'd0,1);
        add(1,1,8'h05, 0,6'h05,8'h02,0,8'h00,0,8'd0,1);
        add(1,1,8'h00, 0,6'h05,8'h02,1,8'hA5,0,8'd0,1);
        add(1,1,8'hFF, 0,6'h05,8'h02,1,8'hA5,0,8'd0,1);
        add(1,0,8'h00, 0,6'h05,8'h02,0,8'hA5,0,8'd0,1);
        add(0,0,8'h00, 0,6'h05,8'h02,0,8'hA5,0,8'd0,0);
        add(1,0,8'h00, 0,6'h05,8'h02,0,8'hA5,0,8'd0,1);
        add(1,1,8'h7F, 0,6'h3F,8'h02,0,8'hA5,0,8'd0,1);
        add(1,1,8'h00, 0,6'h00,8'h02,1,8'h00,1,8'd0,1);
        add(0,0,8'h00, 0,6'h00,8'h02,0,8'h00,1,8'd0,0);

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'(outs_now()), 64'({1'b0, 6'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].cs, tv[i].v, tv[i].d);
            chk($sformatf("vec%0d", i), 64'(outs_now()),
                64'({tv[i].we, tv[i].a, tv[i].wd, tv[i].rv, tv[i].rd, tv[i].err, tv[i].cnt, tv[i].busy}));
        end

        // reset in the cycle a write pulse is up, with cs held high throughout
        step(0,0,8'h00); step(1,0,8'h00); step(1,1,8'hC0);
        step(1,1,8'h99);
        chk("prereset_we", 64'(we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_midwrite", 64'(outs_now()), 64'({1'b0, 6'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        obs_w.delete();
        step(1,1,8'h81); step(1,1,8'h44); step(1,0,8'h00);
        chk("post_reset_ignored", 64'(obs_w.size()), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd1);
        step(0,0,8'h00);
        chk("post_reset_idle", 64'(busy), 64'd0);
        step(1,0,8'h00); step(1,1,8'h82); step(1,1,8'h6B); step(1,0,8'h00);
        chk("next_frame_nw", 64'(obs_w.size()), 64'd1);
        if (obs_w.size() > 0) chk("next_frame_w", 64'(obs_w[0]), 64'({6'd2, 8'h6B}));

        // write counter saturation
        step(0,0,8'h00); step(1,0,8'h00); step(1,1,8'h80);
        last = 8'h00;
        for (int k = 0; k < 257; k++) begin
            last = 8'(k * 7);
            step(1,1,last);
        end
        step(1,0,8'h00);
        chk("wr_count_sat", 64'(cnt), 64'd255);
        chk("sat_last_data", 64'(wd), 64'(last));
        step(0,0,8'h00);

        // random frames against a frame-level model
        rf_fix_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
            mem_ref[i] = mem[i];
        end
        for (int f = 0; f < 150; f++) begin
            logic        rw, inc, e;
            logic [5:0]  a;
            logic [7:0]  b;
            int          n, wc;
            logic [13:0] ew[$];
            logic [7:0]  er[$];
            rw = 1'($urandom); inc = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(RC - 2, 63)) : 6'($urandom_range(0, 63));
            n = $urandom_range(0, 10);
            obs_w.delete(); obs_r.delete(); ew.delete(); er.delete();
            e = 1'b0; wc = 0;
            step(0,0,8'h00); step(1,0,8'h00); step(1,1,{rw, inc, a});
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                repeat ($urandom_range(0, 2)) step(1,0,8'($urandom));
                step(1,1,b);
                if (int'(a) >= RC) e = 1'b1;
                if (rw && int'(a) < RC) begin
                    ew.push_back({a, b});
                    mem_ref[a] = b;
                    wc++;
                end
                if (!rw) er.push_back(int'(a) < RC ? mem_ref[a] : 8'h00);
                if (inc) a = (int'(a) + 1 >= RC) ? 6'd0 : a + 6'd1;
            end
            step(1,0,8'h00);
            step(0,1'($urandom),8'($urandom));
            chk($sformatf("rnd%0d_nw", f), 64'(obs_w.size()), 64'(ew.size()));
            for (int k = 0; k < ew.size() && k < obs_w.size(); k++)
                chk($sformatf("rnd%0d_w%0d", f, k), 64'(obs_w[k]), 64'(ew[k]));
            chk($sformatf("rnd%0d_nr", f), 64'(obs_r.size()), 64'(er.size()));
            for (int k = 0; k < er.size() && k < obs_r.size(); k++)
                chk($sformatf("rnd%0d_r%0d", f, k), 64'(obs_r[k]), 64'(er[k]));
            chk($sformatf("rnd%0d_err", f), 64'(err), 64'(e));
            chk($sformatf("rnd%0d_cnt", f), 64'(cnt), 64'(wc));
            chk($sformatf("rnd%0d_busy", f), 64'(busy), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/project_reg_access_ctrl.md
PROJECT_REG_ACCESS_CTRL -- requirements
Module: project_reg_access_ctrl

Interface
REQ-001 SHALL have parameter REG_COUNT, default 49, number of implemented register-file locations (valid addresses 0..REG_COUNT-1).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_host_cs  input  1  frame select from the host, active high.
REQ-005 SHALL have port i_host_valid  input  1  byte strobe, one byte per high cycle.
REQ-006 SHALL have port i_host_data  input  8  host byte.
REQ-007 SHALL have port o_host_rdata  output  8  read-back byte.
REQ-008 SHALL have port o_host_rvalid  output  1  one-cycle pulse; o_host_rdata is valid in that cycle.
REQ-009 SHALL have ports o_rf_write_en  output  1, o_rf_address  output  6 and o_rf_data  output  8; these drive the register-file write port.
REQ-010 SHALL have port i_rf_data  input  8  combinational register-file read data for o_rf_address.
REQ-011 SHALL have ports o_busy  output  1 (state != IDLE), o_err  output  1 (sticky address error) and o_wr_count  output  8 (accepted writes in the current frame, saturating).

Function
REQ-012 SHALL implement states IDLE, CMD, WDATA, RDATA and WAIT_CS_LOW.
REQ-013 SHALL register i_host_cs; cs_rise means cs high now and low last cycle.
REQ-014 IDLE: SHALL go to CMD on cs_rise; clear o_err and o_wr_count on the same edge.
REQ-015 CMD: a valid byte SHALL be decoded as bit7 rw (1 = write), bit6 inc (auto-increment) and bits5:0 start address; load the address pointer; go to WDATA if rw=1, else RDATA.
REQ-016 WDATA: each valid byte SHALL produce, on the next edge, o_rf_write_en=1 for exactly one cycle, with o_rf_address = pointer and o_rf_data = byte; o_wr_count increments, saturating at 255.
REQ-017 RDATA: each valid byte (content ignored) SHALL cause o_host_rdata <= i_rf_data (with o_rf_address = pointer) and o_host_rvalid=1 on the next edge; latency is 1 cycle.
REQ-018 After each data access, if inc=1 the pointer SHALL increment, wrapping from REG_COUNT-1 to 0; if inc=0 it holds.
REQ-019 Pointer >= REG_COUNT: a write SHALL be suppressed (no o_rf_write_en pulse, no count); a read SHALL return 0x00 with rvalid; o_err set to 1 in both cases; an out-of-range pointer with inc=1 wraps to 0 after the access.
REQ-020 cs low in any non-IDLE state SHALL force IDLE on the next edge; a valid byte in that same cycle is ignored.
REQ-021 Valid bytes while cs is low, or in IDLE, SHALL be ignored.
REQ-022 o_rf_write_en SHALL never be high in two consecutive cycles unless valid was high in two consecutive cycles; back-to-back valids are supported at full rate.
REQ-023 o_rf_address SHALL equal the pointer whenever o_rf_write_en=0, so that i_rf_data tracks it.

Reset
REQ-024 Reset assertion SHALL immediately set state=WAIT_CS_LOW, pointer=0, o_rf_write_en=0, o_rf_address=0, o_rf_data=0, o_host_rdata=0, o_host_rvalid=0, o_err=0 and o_wr_count=0.
REQ-025 WAIT_CS_LOW SHALL go to IDLE only after i_host_cs is sampled low, so a frame cut by reset is never resumed; o_busy is 1 in this state.
REQ-026 Reset asserted mid-write SHALL abort the pending o_rf_write_en pulse.

Verification
REQ-027 Write burst: cs rise, bytes 0xC3, 0x11, 0x22, 0x33 -> writes to addresses 3, 4 and 5 with data 0x11, 0x22 and 0x33 on consecutive cycles; o_wr_count=3.
REQ-028 Read no-inc: cs rise, 0x05 then 2 dummies with i_rf_data=0xA5 -> two rvalid pulses with 0xA5, each 1 cycle after its byte; o_rf_address stays 5.
REQ-029 Wrap: cmd 0xF0 (write, inc, addr 48), bytes 0x01, 0x02 -> writes addr 48=0x01, then addr 0=0x02; o_err=0.
REQ-030 Range error: cmd 0xB5 (write, addr 53), byte 0x7E -> no write pulse; o_err=1, held until the next cs_rise, where it clears.
REQ-031 Abort: cs drops in the same cycle as a valid data byte -> no write; state IDLE next cycle; o_busy=0.
REQ-032 Reset mid-frame with cs held high -> outputs at reset values; subsequent bytes ignored until cs low then a new cs rise; next frame works normally.
